ans_decoder_rans: RTL and testbench
===================================

Name: ans_decoder_rans

Overview:
- Parametrised successor to the fixed 16-symbol/4-bit ANS decoder: a streaming rANS decoder with configurable alphabet size, probability precision, state width and input digit width.
- Consumes a digit stream over valid/ready, emits decoded symbols over valid/ready, and decodes a framed message of programmable length.
- New capabilities: frame start/length control, end-of-frame marking, and final-state integrity checking.
- Sits between the input-nibble FIFO and the symbol sink in the decompression datapath.

Parameters:
- SYM_BITS, 4, symbol width; NSYM = 2^SYM_BITS table entries.
- PROB_BITS, 8, precision; table total M = 2^PROB_BITS.
- STATE_BITS, 16, rANS state width; L = 2^(STATE_BITS-IN_BITS). Requires STATE_BITS-IN_BITS >= PROB_BITS.
- IN_BITS, 4, input digit width; STATE_BITS must be a multiple of IN_BITS.
- LEN_BITS, 16, width of the frame symbol count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; low freezes all state
- counts_unpacked  in  NSYM*PROB_BITS  cnt[i] at bits [i*PROB_BITS +: PROB_BITS]
- cumulative_unpacked  in  NSYM*PROB_BITS  cum[i], same packing
- start  in  1  one-cycle frame start, honoured only in IDLE
- num_symbols  in  LEN_BITS  symbols in frame, sampled on start
- in  in  IN_BITS  input digit
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- out  out  SYM_BITS  decoded symbol
- out_vld  out  1  output valid
- out_rdy  in  1  output ready
- out_last  out  1  qualifies out as the final symbol of the frame
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at frame end
- state_err  out  1  final state != L; valid with done, held until the next start

Behaviour:
- Reset: FSM=IDLE, x=0, remaining=0; in_rdy, out_vld, out_last, busy, done and state_err all 0; out=0.
- Tables are not latched. They must be stable from start until done, with sum(cnt)=M and cum[i] = sum of cnt[j] for j<i over nonzero entries.
- Handshake: transfer occurs when vld&&rdy at a clk edge. out_vld, once high, stays high with out and out_last stable until accepted. in_rdy is high only in LOAD and RENORM.
- ena=0: no state changes; in_rdy and out_vld are forced 0. On return to 1, the FSM resumes unchanged.
- IDLE: on start with num_symbols=0, pulse done next cycle with state_err=0 and consume no input. Otherwise set remaining=num_symbols, x=0, go to LOAD.
- LOAD: accept STATE_BITS/IN_BITS digits, most significant digit first: x=(x<<IN_BITS)|in. After the last digit, go to EMIT.
- EMIT (combinational from x):
  - slot = x[PROB_BITS-1:0].
  - s = highest i with cnt[i]!=0 and cum[i]<=slot.
  - out=s, out_vld=1, out_last=(remaining==1).
  - On accept: x = cnt[s]*(x>>PROB_BITS) + slot - cum[s], truncated to STATE_BITS; remaining decrements; go to RENORM.
- RENORM:
  - If x>=L: go to EMIT, or to DONE if remaining==0, without asserting in_rdy.
  - Else accept digits, x=(x<<IN_BITS)|in, one per handshake, until x>=L.
  - Renorm runs after every symbol, including the last.
- DONE: state_err=(x!=L), done=1 for one cycle, then IDLE.
- start while busy: ignored.
- Latency: first out_vld is 1 cycle after the final LOAD digit; one symbol per cycle when no renorm digits are needed.

Decomposition:
- Package ans_pkg holds:
  - the FSM state enum (IDLE, LOAD, EMIT, RENORM, DONE);
  - localparams NSYM, M and L;
  - table field-extract functions.
- Sub-module ans_symbol_lookup: purely combinational, parallel compare of slot against cum/cnt, with a priority encoder to s. Outputs s, cnt[s] and cum[s].

Test Plan:
- Uniform table (cnt=16, cum=16*i), start num_symbols=1, in digits 1,0,3,0,0 -> out=3 with out_last=1, all 5 digits consumed, done pulse, state_err=0, final x=0x1000.
- Table cnt{128,64,16,16,16,16,0..}, cum{0,128,192,208,224,240}, num_symbols=1, digits 1,0,0,0,0 -> out=0, x'=0x800, one renorm digit gives x=0x8000, done with state_err=1.
- Uniform table, num_symbols=2, state 0x1234 -> first out=3, x'=0x124, renorm consumes exactly one digit before the second out_vld.
- Backpressure: out_rdy low for 5 cycles during EMIT -> out_vld held, out stable, in_rdy=0, x unchanged; accepted on the first out_rdy=1.
- ena low for 3 cycles mid-LOAD, and start pulsed while busy -> no digits consumed, start ignored, decode completes as the reference model.
- rst_n asserted mid-RENORM -> all outputs 0 immediately; next start decodes a fresh frame correctly.

Source files
------------

// File: rtl/ans_pkg.sv
// Shared types and defaults for the streaming rANS decoder: FSM state
// encoding, default geometry and frequency-table field extraction.
package ans_pkg;

  localparam int DEF_SYM_BITS   = 4;
  localparam int DEF_PROB_BITS  = 8;
  localparam int DEF_STATE_BITS = 16;
  localparam int DEF_IN_BITS    = 4;
  localparam int DEF_LEN_BITS   = 16;

  localparam int NSYM = 2 ** DEF_SYM_BITS;
  localparam int M    = 2 ** DEF_PROB_BITS;
  localparam int L    = 2 ** (DEF_STATE_BITS - DEF_IN_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EMIT   = 3'd2,
    RENORM = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Entry idx of a packed table at the default geometry.
  function automatic logic [DEF_PROB_BITS-1:0] tbl_field(
    input logic [NSYM*DEF_PROB_BITS-1:0] tbl,
    input logic [DEF_SYM_BITS-1:0]       idx
  );
    return tbl[idx*DEF_PROB_BITS +: DEF_PROB_BITS];
  endfunction

endpackage

// File: rtl/ans_symbol_lookup.sv
// Combinational slot-to-symbol search: every entry is compared in parallel,
// and the highest populated entry whose cumulative start is <= slot wins.
module ans_symbol_lookup #(
  parameter int SYM_BITS  = 4,
  parameter int PROB_BITS = 8
) (
  input  logic [(2**SYM_BITS)*PROB_BITS-1:0] counts,
  input  logic [(2**SYM_BITS)*PROB_BITS-1:0] cums,
  input  logic [PROB_BITS-1:0]               slot,
  output logic [SYM_BITS-1:0]                sym,
  output logic [PROB_BITS-1:0]               sym_cnt,
  output logic [PROB_BITS-1:0]               sym_cum
);

  localparam int NS = 2 ** SYM_BITS;

  logic [NS-1:0] hit_s;

  for (genvar i = 0; i < NS; i++) begin : g_cmp
    assign hit_s[i] = (counts[i*PROB_BITS +: PROB_BITS] != '0) &&
                      (cums[i*PROB_BITS +: PROB_BITS] <= slot);
  end

  // Priority encoder: later (higher) hits override earlier ones.
  always_comb begin
    sym     = '0;
    sym_cnt = '0;
    sym_cum = '0;
    for (int i = 0; i < NS; i++) begin
      sym     = hit_s[i] ? SYM_BITS'(i) : sym;
      sym_cnt = hit_s[i] ? counts[i*PROB_BITS +: PROB_BITS] : sym_cnt;
      sym_cum = hit_s[i] ? cums[i*PROB_BITS +: PROB_BITS] : sym_cum;
    end
  end

endmodule

// File: rtl/ans_decoder_rans.sv
// Framed streaming rANS decoder: loads the initial state MSD-first, emits one
// symbol per handshake, renormalises from the digit stream, checks final state.
module ans_decoder_rans
  import ans_pkg::*;
#(
  parameter int SYM_BITS   = DEF_SYM_BITS,
  parameter int PROB_BITS  = DEF_PROB_BITS,
  parameter int STATE_BITS = DEF_STATE_BITS,
  parameter int IN_BITS    = DEF_IN_BITS,
  parameter int LEN_BITS   = DEF_LEN_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic [(2**SYM_BITS)*PROB_BITS-1:0] counts_unpacked,
  input  logic [(2**SYM_BITS)*PROB_BITS-1:0] cumulative_unpacked,
  input  logic                               start,
  input  logic [LEN_BITS-1:0]                num_symbols,
  input  logic [IN_BITS-1:0]                 in,
  input  logic                               in_vld,
  output logic                               in_rdy,
  output logic [SYM_BITS-1:0]                out,
  output logic                               out_vld,
  input  logic                               out_rdy,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               state_err
);

  localparam int NDIG = STATE_BITS / IN_BITS;
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [STATE_BITS-1:0] L_VAL = STATE_BITS'(1) << (STATE_BITS - IN_BITS);

  state_t                state_r;
  logic [STATE_BITS-1:0] x_r;
  logic [LEN_BITS-1:0]   remaining_r;
  logic [DW-1:0]         load_cnt_r;
  logic                  in_rdy_r;
  logic                  out_vld_r;
  logic                  done_r;
  logic                  state_err_r;

  logic [SYM_BITS-1:0]   sym_s;
  logic [PROB_BITS-1:0]  sym_cnt_s;
  logic [PROB_BITS-1:0]  sym_cum_s;
  logic [PROB_BITS-1:0]  slot_s;
  logic [STATE_BITS-1:0] x_dec_s;
  logic [STATE_BITS-1:0] x_shift_s;
  logic [LEN_BITS-1:0]   rem_dec_s;
  logic                  in_fire_s;
  logic                  out_fire_s;

  assign slot_s = x_r[PROB_BITS-1:0];

  ans_symbol_lookup #(
    .SYM_BITS  (SYM_BITS),
    .PROB_BITS (PROB_BITS)
  ) u_lookup (
    .counts  (counts_unpacked),
    .cums    (cumulative_unpacked),
    .slot    (slot_s),
    .sym     (sym_s),
    .sym_cnt (sym_cnt_s),
    .sym_cum (sym_cum_s)
  );

  // Decode step, naturally truncated to the state width.
  assign x_dec_s = ({{(STATE_BITS-PROB_BITS){1'b0}}, sym_cnt_s} * (x_r >> PROB_BITS))
                 + {{(STATE_BITS-PROB_BITS){1'b0}}, slot_s}
                 - {{(STATE_BITS-PROB_BITS){1'b0}}, sym_cum_s};
  assign x_shift_s = {x_r[STATE_BITS-IN_BITS-1:0], in};
  assign rem_dec_s = remaining_r - LEN_BITS'(1);

  assign in_rdy     = in_rdy_r & ena;
  assign out_vld    = out_vld_r & ena;
  assign in_fire_s  = in_vld & in_rdy;
  assign out_fire_s = out_vld & out_rdy;
  assign out        = (state_r == EMIT) ? sym_s : '0;
  assign out_last   = out_vld_r && (remaining_r == LEN_BITS'(1));
  assign busy       = (state_r != IDLE);
  assign done       = done_r;
  assign state_err  = state_err_r;

  // Frame FSM; when renorm is not needed EMIT chains straight into the next
  // symbol so the decoder sustains one symbol per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      x_r         <= '0;
      remaining_r <= '0;
      load_cnt_r  <= '0;
      in_rdy_r    <= 1'b0;
      out_vld_r   <= 1'b0;
      done_r      <= 1'b0;
      state_err_r <= 1'b0;
    end else if (ena) begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_err_r <= 1'b0;
            if (num_symbols == '0) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              remaining_r <= num_symbols;
              x_r         <= '0;
              load_cnt_r  <= '0;
              in_rdy_r    <= 1'b1;
              state_r     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_fire_s) begin
            x_r <= x_shift_s;
            if (load_cnt_r == DW'(NDIG - 1)) begin
              in_rdy_r  <= 1'b0;
              out_vld_r <= 1'b1;
              state_r   <= EMIT;
            end else begin
              load_cnt_r <= load_cnt_r + DW'(1);
            end
          end
        end
        EMIT: begin
          if (out_fire_s) begin
            x_r         <= x_dec_s;
            remaining_r <= rem_dec_s;
            if (x_dec_s < L_VAL) begin
              out_vld_r <= 1'b0;
              in_rdy_r  <= 1'b1;
              state_r   <= RENORM;
            end else if (rem_dec_s == '0) begin
              out_vld_r   <= 1'b0;
              done_r      <= 1'b1;
              state_err_r <= (x_dec_s != L_VAL);
              state_r     <= DONE;
            end else begin
              state_r <= EMIT;
            end
          end
        end
        RENORM: begin
          if (in_fire_s) begin
            x_r <= x_shift_s;
            if (x_shift_s >= L_VAL) begin
              in_rdy_r <= 1'b0;
              if (remaining_r == '0) begin
                done_r      <= 1'b1;
                state_err_r <= (x_shift_s != L_VAL);
                state_r     <= DONE;
              end else begin
                out_vld_r <= 1'b1;
                state_r   <= EMIT;
              end
            end
          end
        end
        DONE: state_r <= IDLE;
        default: begin
          in_rdy_r  <= 1'b0;
          out_vld_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ans_decoder_rans.sv
// Scoreboard bench for ans_decoder_rans: an integer rANS reference model fills
// expectation queues; a separate monitor pops and compares on every transfer.
module tb_ans_decoder_rans;

  localparam int SB = 4, PB = 8, STB = 16, IB = 4, LB = 16;
  localparam int NS = 16, MM = 256, LL = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic [NS*PB-1:0]  counts_unpacked = '0;
  logic [NS*PB-1:0]  cumulative_unpacked = '0;
  logic              start = 1'b0;
  logic [LB-1:0]     num_symbols = '0;
  logic [IB-1:0]     in = '0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [SB-1:0]     out;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              state_err;

  int n_vec = 0;
  int n_bad = 0;
  int cnt[NS];
  int cum[NS];
  int digits[$];
  int used;
  int ptr;
  int exp_sym_q[$];
  bit exp_last_q[$];
  bit exp_err_q[$];
  int done_seen = 0;
  int bp_hold = 0;
  bit pend = 1'b0;
  logic [SB-1:0] pout;
  logic          plast;

  ans_decoder_rans dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ena                 (ena),
    .counts_unpacked     (counts_unpacked),
    .cumulative_unpacked (cumulative_unpacked),
    .start               (start),
    .num_symbols         (num_symbols),
    .in                  (in),
    .in_vld              (in_vld),
    .in_rdy              (in_rdy),
    .out                 (out),
    .out_vld             (out_vld),
    .out_rdy             (out_rdy),
    .out_last            (out_last),
    .busy                (busy),
    .done                (done),
    .state_err           (state_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_rdy"}, in_rdy, 0);
    check({tag, "_out_vld"}, out_vld, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state_err"}, state_err, 0);
    check({tag, "_out"}, out, 0);
  endtask

  task automatic pack_table();
    int run;
    run = 0;
    for (int i = 0; i < NS; i++) begin
      cum[i] = run;
      run += cnt[i];
      counts_unpacked[i*PB +: PB]     = PB'(cnt[i]);
      cumulative_unpacked[i*PB +: PB] = PB'(cum[i]);
    end
  endtask

  task automatic uniform_table();
    for (int i = 0; i < NS; i++) cnt[i] = 16;
    pack_table();
  endtask

  // Random table: k populated entries, each at least 1, summing to M.
  task automatic random_table();
    int k, left, j;
    k = $urandom_range(NS, 2);
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    left = k;
    while (left > 0) begin
      j = $urandom_range(NS - 1, 0);
      if (cnt[j] == 0) begin cnt[j] = 1; left--; end
    end
    left = MM - k;
    while (left > 0) begin
      j = $urandom_range(NS - 1, 0);
      if (cnt[j] != 0 && cnt[j] < 255) begin cnt[j]++; left--; end
    end
    pack_table();
  endtask

  task automatic gen_digits(input int num);
    digits.delete();
    digits.push_back($urandom_range(15, 1));
    for (int i = 0; i < 3 + 3 * num + 4; i++) digits.push_back($urandom_range(15, 0));
  endtask

  // Reference decoder: symbol s owns slots [cum[s], cum[s]+cnt[s]).
  task automatic model_frame(input int num);
    longint x;
    int p, slot, s;
    p = 0;
    x = 0;
    if (num > 0) begin
      for (int k = 0; k < STB / IB; k++) begin x = x * 16 + digits[p]; p++; end
      for (int n = 0; n < num; n++) begin
        slot = int'(x % MM);
        s = 0;
        for (int i = 0; i < NS; i++)
          if (slot >= cum[i] && slot < cum[i] + cnt[i]) s = i;
        exp_sym_q.push_back(s);
        exp_last_q.push_back(n == num - 1);
        x = (cnt[s] * (x / MM) + slot - cum[s]) % 65536;
        while (x < LL) begin x = x * 16 + digits[p]; p++; end
      end
    end
    exp_err_q.push_back(num > 0 && x != LL);
    used = p;
  endtask

  task automatic flush_and_reset();
    exp_sym_q.delete();
    exp_last_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0 normal, 1 ena gap + start while busy, 2 reset mid-renorm, 3 backpressure
  task automatic run_frame(input int num, input int mode);
    int d0, gap;
    bit aborted, lat_chk;
    model_frame(num);
    d0 = done_seen;
    gap = 0;
    aborted = 1'b0;
    lat_chk = 1'b0;
    @(negedge clk);
    num_symbols = LB'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_symbols = LB'($urandom_range(20, 0));
    if (mode == 3) bp_hold = 5;
    ptr = 0;
    for (int cyc = 0; cyc < 3000 && done_seen == d0 && !aborted; cyc++) begin
      @(negedge clk);
      if (mode == 1 && ptr == 2 && gap < 3) begin
        ena = 1'b0;
        gap++;
        in_vld = 1'b1;
      end else begin
        ena = 1'b1;
        in_vld = (ptr < used) && ($urandom_range(3, 0) != 0);
      end
      in = (ptr < digits.size()) ? IB'(digits[ptr]) : '0;
      start = (mode == 1 && cyc == 8);
      #1;
      if (start) check("busy_when_restarted", busy, 1);
      if (!ena) check("in_rdy_while_disabled", in_rdy, 0);
      if (lat_chk) begin
        check("first_out_latency", out_vld, 1);
        lat_chk = 1'b0;
      end
      if (in_vld && in_rdy) begin
        ptr++;
        lat_chk = (ptr == STB / IB);
      end
      if (mode == 2 && ptr >= STB / IB && in_rdy && exp_sym_q.size() == num - 1) begin
        rst_n = 1'b0;
        #2;
        check_all_zero("reset_mid_renorm");
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    in_vld = 1'b0;
    ena = 1'b1;
    if (aborted) begin
      flush_and_reset();
    end else if (done_seen == d0) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_timeout: got no done, required done for %0d symbols", num);
      rst_n = 1'b0;
      flush_and_reset();
    end else begin
      check("digits_consumed", ptr, used);
      check("symbols_outstanding", exp_sym_q.size(), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  // Output backpressure: random, or held low for a fixed number of EMIT cycles.
  initial forever begin
    @(negedge clk);
    if (bp_hold > 0) begin
      out_rdy = 1'b0;
      if (out_vld) bp_hold--;
    end else begin
      out_rdy = ($urandom_range(3, 0) != 0);
    end
  end

  // Monitor: compare each accepted symbol and each done against the queues.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend && ena) begin
        check("held_out_vld", out_vld, 1);
        check("held_out", out, pout);
        check("held_out_last", out_last, plast);
      end
      if (out_vld) check("in_rdy_during_emit", in_rdy, 0);
      if (out_vld && out_rdy) begin
        if (exp_sym_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_symbol: got %0h, required none", out);
        end else begin
          check("out", out, exp_sym_q.pop_front());
          check("out_last", out_last, exp_last_q.pop_front());
        end
        pend = 1'b0;
      end else begin
        pend = out_vld;
        pout = out;
        plast = out_last;
      end
      if (done) begin
        done_seen++;
        if (exp_err_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done, required none");
        end else begin
          check("state_err", state_err, exp_err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ena = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Uniform table, one symbol from 0x1030 then one renorm digit.
    uniform_table();
    gen_digits(1);
    digits[0] = 1; digits[1] = 0; digits[2] = 3; digits[3] = 0; digits[4] = 0;
    run_frame(1, 0);

    // Skewed table: final state 0x8000 flags an integrity error.
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    cnt[0] = 128; cnt[1] = 64;
    for (int i = 2; i < 6; i++) cnt[i] = 16;
    pack_table();
    gen_digits(1);
    digits[0] = 1; digits[1] = 0; digits[2] = 0; digits[3] = 0; digits[4] = 0;
    run_frame(1, 0);

    // Two symbols from 0x1234; one renorm digit between them.
    uniform_table();
    gen_digits(2);
    digits[0] = 1; digits[1] = 2; digits[2] = 3; digits[3] = 4;
    run_frame(2, 0);

    random_table();
    gen_digits(4);
    run_frame(4, 3);

    random_table();
    gen_digits(5);
    run_frame(5, 1);

    uniform_table();
    gen_digits(2);
    digits[0] = 1; digits[1] = 2; digits[2] = 3; digits[3] = 4;
    run_frame(2, 2);
    random_table();
    gen_digits(3);
    run_frame(3, 0);

    gen_digits(0);
    run_frame(0, 0);

    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(12, 1);
      random_table();
      gen_digits(n);
      run_frame(n, (f % 4 == 3) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
